// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types and constants for the RV32I fetch stage.
//   fetch_state_t    : fetch controller states
//   NOP_INSTR        : canonical NOP (addi x0,x0,0) shown when nothing is valid
//   RESET_PC_DEFAULT : PC of the first fetch after reset
//   align_word()     : clears the low two bits of a target address
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,  // read in flight; data is bypassed straight to ir_out
      HOLD    = 2'd1,  // word buffered because IF/ID was not accepting
      DISCARD = 2'd2   // read in flight for a squashed PC; its data is thrown away
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h6000_0000;

   // Instruction addresses are word aligned; low bits of a target are ignored.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the 5-stage RV32I pipeline. Owns the PC, issues reads to the
// instruction memory and hands {instruction, PC} pairs to IF/ID. Absorbs memory
// wait states, downstream stalls and redirects, including a redirect that lands
// while a read is still outstanding (that read is completed and its data
// dropped, since the memory cannot abort it).
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   imem_address     : read address (always pc_q)
//   imem_read        : read request, held with a stable address until imem_resp
//   imem_rdata       : instruction word, valid with imem_resp
//   imem_resp        : one-cycle completion pulse for the outstanding read
//   advance          : IF/ID accepts this cycle
//   redirect         : control transfer resolved; squash the in-flight fetch
//   redirect_target  : new PC on redirect (bits [1:0] ignored)
//   fetch_valid      : ir_out/pc_out carry a real instruction
//   ir_out           : instruction (NOP_INSTR when not valid)
//   pc_out           : PC of ir_out
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        fetch_valid,
   output logic [31:0] ir_out,
   output logic [31:0] pc_out
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pend_q;
   logic [31:0]  ir_buf_q;

   logic [31:0]  target;
   logic [31:0]  pc_plus4;

   assign target   = align_word(redirect_target);
   assign pc_plus4 = pc_q + 32'd4;   // wraps silently at 2^32

   // Outputs are gated by rst so nothing leaks during the reset cycle, even
   // though state_q only clears on the following edge.
   assign imem_address = pc_q;
   assign imem_read    = ~rst & ((state_q == FETCH) | (state_q == DISCARD));
   assign fetch_valid  = ~rst & ~redirect &
                         (((state_q == FETCH) & imem_resp) | (state_q == HOLD));
   assign pc_out       = pc_q;

   // FETCH bypasses memory data combinationally so a same-cycle response costs
   // no extra latency.
   always_comb begin
      ir_out = NOP_INSTR;
      if (fetch_valid) begin
         ir_out = (state_q == HOLD) ? ir_buf_q : imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         pend_q   <= 32'd0;
         ir_buf_q <= NOP_INSTR;
      end else begin
         case (state_q)
            FETCH: begin
               if (redirect) begin
                  if (imem_resp) begin
                     pc_q <= target;
                  end else begin
                     // Read still outstanding at the old address: remember
                     // the target and drop the response when it arrives.
                     pend_q  <= target;
                     state_q <= DISCARD;
                  end
               end else if (imem_resp) begin
                  if (advance) begin
                     pc_q <= pc_plus4;
                  end else begin
                     ir_buf_q <= imem_rdata;
                     state_q  <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_q    <= target;
                  state_q <= FETCH;
               end else if (advance) begin
                  pc_q    <= pc_plus4;
                  state_q <= FETCH;
               end
            end
            DISCARD: begin
               if (redirect) begin
                  pend_q <= target;   // newest redirect wins
               end
               if (imem_resp) begin
                  pc_q    <= redirect ? target : pend_q;
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Inputs change just after the falling edge;
// outputs are compared 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_address;
   logic        imem_read;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        advance;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        fetch_valid;
   logic [31:0] ir_out;
   logic [31:0] pc_out;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .imem_address    (imem_address),
      .imem_read       (imem_read),
      .imem_rdata      (imem_rdata),
      .imem_resp       (imem_resp),
      .advance         (advance),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .fetch_valid     (fetch_valid),
      .ir_out          (ir_out),
      .pc_out          (pc_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         $display("ok   %-24s got %h", tag, obs);
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, let them settle.
   task automatic step(input logic r, input logic resp, input logic [31:0] rdata,
                       input logic adv, input logic redir, input logic [31:0] tgt);
      @(negedge clk);
      rst             = r;
      imem_resp       = resp;
      imem_rdata      = rdata;
      advance         = adv;
      redirect        = redir;
      redirect_target = tgt;
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; imem_resp = 1'b0; imem_rdata = 32'h0;
      advance = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

      // ---- 1: reset state, then back-to-back single-cycle fetches
      do_reset();
      chk("rst_imem_read",  {31'd0, imem_read},   32'd0);
      chk("rst_fetch_valid",{31'd0, fetch_valid}, 32'd0);
      chk("rst_ir_out",     ir_out,               NOP);
      step(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
      chk("t1_read0",  {31'd0, imem_read},   32'd1);
      chk("t1_pc0",    pc_out,               32'h6000_0000);
      chk("t1_valid0", {31'd0, fetch_valid}, 32'd1);
      chk("t1_ir0",    ir_out,               32'h1111_1111);
      step(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
      chk("t1_pc1",    pc_out,               32'h6000_0004);
      chk("t1_valid1", {31'd0, fetch_valid}, 32'd1);
      step(1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
      chk("t1_pc2",    pc_out,               32'h6000_0008);
      chk("t1_valid2", {31'd0, fetch_valid}, 32'd1);

      // ---- 2: three wait states
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
         chk("t2_wait_valid", {31'd0, fetch_valid}, 32'd0);
         chk("t2_wait_addr",  imem_address,         32'h6000_0000);
         chk("t2_wait_ir",    ir_out,               NOP);
      end
      // ---- 3: response while IF/ID stalls -> HOLD
      step(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'h0);
      chk("t2_resp_valid", {31'd0, fetch_valid}, 32'd1);
      chk("t2_resp_ir",    ir_out,               32'h00A0_0093);
      chk("t2_resp_addr",  imem_address,         32'h6000_0000);
      step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      chk("t3_hold_read",  {31'd0, imem_read},   32'd0);
      chk("t3_hold_valid", {31'd0, fetch_valid}, 32'd1);
      chk("t3_hold_ir",    ir_out,               32'h00A0_0093);
      step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk("t3_xfer_valid", {31'd0, fetch_valid}, 32'd1);
      chk("t3_xfer_ir",    ir_out,               32'h00A0_0093);
      step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk("t3_next_addr",  imem_address,         32'h6000_0004);
      chk("t3_next_read",  {31'd0, imem_read},   32'd1);

      // ---- 4: redirect during an outstanding read of 6000_0008
      step(1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0);   // 6000_0004 transfers
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0100);
      chk("t4_redir_valid", {31'd0, fetch_valid}, 32'd0);
      chk("t4_redir_addr",  imem_address,         32'h6000_0008);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t4_disc_addr",   imem_address,         32'h6000_0008);
      chk("t4_disc_read",   {31'd0, imem_read},   32'd1);
      step(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0);
      chk("t4_drop_valid",  {31'd0, fetch_valid}, 32'd0);
      chk("t4_drop_ir",     ir_out,               NOP);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t4_new_addr",    imem_address,         32'h6000_0100);

      // ---- 5: newest of several redirects during DISCARD wins
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0400);   // enter DISCARD
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0100);
      chk("t5_disc_addr",   imem_address,         32'h6000_0100);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0200);
      step(1'b0, 1'b1, 32'hBAD1_BAD1, 1'b1, 1'b0, 32'h0);
      chk("t5_drop_valid",  {31'd0, fetch_valid}, 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t5_new_addr",    imem_address,         32'h6000_0200);
      // misaligned target: resp coincident, so redirect applies directly
      step(1'b0, 1'b1, 32'hBAD2_BAD2, 1'b1, 1'b1, 32'h6000_0103);
      chk("t5_mis_valid",   {31'd0, fetch_valid}, 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t5_mis_addr",    imem_address,         32'h6000_0100);

      // ---- 6: redirect coincident with resp and advance
      step(1'b0, 1'b1, 32'hBAD3_BAD3, 1'b1, 1'b1, 32'h6000_0800);
      chk("t6_co_valid",    {31'd0, fetch_valid}, 32'd0);
      chk("t6_co_ir",       ir_out,               NOP);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t6_co_pc",       pc_out,               32'h6000_0800);
      // PC wrap
      step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0);
      chk("t6_wrap_pc",     pc_out,               32'hFFFF_FFFC);
      chk("t6_wrap_valid",  {31'd0, fetch_valid}, 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t6_wrap_addr",   imem_address,         32'h0000_0000);
      // reset in the middle of DISCARD, stale response lands with reset
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000_0900);   // enter DISCARD
      step(1'b1, 1'b1, 32'hBAD4_BAD4, 1'b1, 1'b0, 32'h0);
      chk("t6_rst_valid",   {31'd0, fetch_valid}, 32'd0);
      chk("t6_rst_read",    {31'd0, imem_read},   32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t6_rst_addr",    imem_address,         32'h6000_0000);
      chk("t6_rst_idle",    {31'd0, fetch_valid}, 32'd0);
      step(1'b0, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
      chk("t6_rst_first",   pc_out,               32'h6000_0000);
      chk("t6_rst_fvalid",  {31'd0, fetch_valid}, 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t6_rst_next",    imem_address,         32'h6000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
